// File: rtl/sd_spi_pkg.sv
// Shared definitions for the SD-card SPI master.
//   state_t          : byte-engine states (IDLE, LO, HI)
//   MIN_HALF_DEFAULT : default minimum SCK half-period in clk cycles
//   MOSI_IDLE        : MOSI level driven while no byte is in flight
package sd_spi_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LO   = 2'd1,
      HI   = 2'd2
   } state_t;

   localparam int unsigned MIN_HALF_DEFAULT = 3;
   localparam logic        MOSI_IDLE        = 1'b1;

endpackage

// File: rtl/sd_spi_sck_gen.sv
// SCK half-period timer for sd_spi_master.
//   clk, reset : clock, synchronous active-high reset
//   load       : byte accepted; latch H = max(clk_div, MIN_HALF) and start phase
//   clk_div    : requested half-period in clk cycles
//   run        : a byte is in flight (LO or HI phase)
//   half_done  : last clk cycle of the current SCK phase
module sd_spi_sck_gen
   import sd_spi_pkg::*;
#(
   parameter int unsigned DIV_W    = 8,
   parameter int unsigned MIN_HALF = MIN_HALF_DEFAULT
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [DIV_W-1:0] clk_div,
   input  logic             run,
   output logic             half_done
);

   localparam logic [DIV_W-1:0] MIN_H = DIV_W'(MIN_HALF);
   localparam logic [DIV_W-1:0] ONE   = DIV_W'(1);

   logic [DIV_W-1:0] half_len;
   logic [DIV_W-1:0] cnt;
   logic [DIV_W-1:0] clamped;

   always_comb begin
      clamped = (clk_div < MIN_H) ? MIN_H : clk_div;
   end

   // Counts H-1 down to 0 in every phase; the zero cycle reloads from the
   // latched H so the counter never wraps on its own.
   always_ff @(posedge clk) begin
      if (reset) begin
         half_len <= MIN_H;
         cnt      <= '0;
      end else if (load) begin
         half_len <= clamped;
         cnt      <= clamped - ONE;
      end else if (run) begin
         if (cnt == '0) begin
            cnt <= half_len - ONE;
         end else begin
            cnt <= cnt - ONE;
         end
      end
   end

   assign half_done = run && (cnt == '0);

endmodule

// File: rtl/sd_spi_master.sv
// Byte-oriented SPI mode-0 master for the SD-card SPI bridge.
//   clk, reset           : clock, synchronous active-high reset
//   clk_div              : SCK half-period in clk cycles (latched at accept)
//   cs_req               : hold chip select asserted
//   tx_valid/tx_data     : byte offered, shifted MSB first
//   tx_ready             : byte can be accepted (IDLE)
//   rx_valid/rx_data     : one-cycle pulse with the received byte
//   busy                 : byte in flight
//   spi_sck, spi_cs      : serial clock (idle low), active-low select
//   spi_dq_o / spi_dq_i  : bit 0 out is MOSI, bit 1 in is synchronized MISO
module sd_spi_master
   import sd_spi_pkg::*;
#(
   parameter int unsigned DIV_W    = 8,
   parameter int unsigned MIN_HALF = MIN_HALF_DEFAULT
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [DIV_W-1:0] clk_div,
   input  logic             cs_req,
   input  logic             tx_valid,
   input  logic [7:0]       tx_data,
   output logic             tx_ready,
   output logic             rx_valid,
   output logic [7:0]       rx_data,
   output logic             busy,
   output logic             spi_sck,
   output logic [3:0]       spi_dq_o,
   input  logic [3:0]       spi_dq_i,
   output logic             spi_cs
);

   state_t     state;
   state_t     next_state;
   logic [7:0] shift;
   logic [2:0] bit_cnt;
   logic       half_done;
   logic       accept;
   logic       run;
   logic       sample;
   logic       miso;
   logic       mosi;
   logic       unused_dq;

   assign miso      = spi_dq_i[1];
   assign unused_dq = ^{spi_dq_i[3:2], spi_dq_i[0]};
   assign accept    = (state == IDLE) && tx_valid;
   assign run       = (state != IDLE);
   // MISO is taken on the last HI cycle rather than at the SCK rise, leaving
   // H-1 cycles for the bridge's two-flop synchronizer to catch up.
   assign sample    = (state == HI) && half_done;

   sd_spi_sck_gen #(
      .DIV_W    (DIV_W),
      .MIN_HALF (MIN_HALF)
   ) u_sck_gen (
      .clk       (clk),
      .reset     (reset),
      .load      (accept),
      .clk_div   (clk_div),
      .run       (run),
      .half_done (half_done)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      tx_ready   = 1'b0;
      busy       = 1'b1;
      spi_sck    = 1'b0;
      mosi       = shift[7];
      case (state)
         IDLE: begin
            tx_ready = 1'b1;
            busy     = 1'b0;
            mosi     = MOSI_IDLE;
            if (tx_valid) begin
               next_state = LO;
            end
         end
         LO: begin
            if (half_done) begin
               next_state = HI;
            end
         end
         HI: begin
            spi_sck = 1'b1;
            if (half_done) begin
               next_state = (bit_cnt == 3'd0) ? IDLE : LO;
            end
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   assign spi_dq_o = {3'b000, mosi};

   always_ff @(posedge clk) begin
      if (reset) begin
         shift    <= '0;
         bit_cnt  <= '0;
         spi_cs   <= 1'b1;
         rx_valid <= 1'b0;
         rx_data  <= '0;
      end else begin
         rx_valid <= 1'b0;
         // CS only follows the request between bytes.
         if (state == IDLE) begin
            spi_cs <= ~cs_req;
         end
         if (accept) begin
            shift   <= tx_data;
            bit_cnt <= 3'd7;
         end else if (sample) begin
            shift <= {shift[6:0], miso};
            if (bit_cnt == 3'd0) begin
               rx_valid <= 1'b1;
               rx_data  <= {shift[6:0], miso};
            end else begin
               bit_cnt <= bit_cnt - 3'd1;
            end
         end
      end
   end

endmodule

// File: tb/tb_sd_spi_master.sv
module tb_sd_spi_master;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] clk_div = 8'd3;
   logic       cs_req = 1'b0;
   logic       tx_valid = 1'b0;
   logic [7:0] tx_data = 8'h00;
   logic       tx_ready;
   logic       rx_valid;
   logic [7:0] rx_data;
   logic       busy;
   logic       spi_sck;
   logic [3:0] spi_dq_o;
   logic [3:0] spi_dq_i;
   logic       spi_cs;

   int unsigned n_total = 0;
   int unsigned n_pass  = 0;
   int unsigned dummy_rises = 0;

   // Card / bridge model: card shifts its byte out one bit per SCK fall, or
   // echoes MOSI in loopback; result passes through a 2-flop synchronizer.
   logic       loop_mode = 1'b1;
   logic [7:0] card_byte = 8'h00;
   int unsigned card_idx = 0;
   logic       card_bit;
   logic       prev_sck_m = 1'b0;
   logic       sync1 = 1'b0;
   logic       sync2 = 1'b0;

   always_comb begin
      card_bit = 1'b1;
      if (loop_mode) card_bit = spi_dq_o[0];
      else if (card_idx <= 7) card_bit = card_byte[7 - card_idx];
   end

   always @(posedge clk) begin
      sync1      <= card_bit;
      sync2      <= sync1;
      prev_sck_m <= spi_sck;
      if (!busy) card_idx <= 0;
      else if (prev_sck_m && !spi_sck) card_idx <= card_idx + 1;
   end

   assign spi_dq_i = {1'b1, 1'b0, sync2, 1'b1};

   sd_spi_master #(
      .DIV_W    (8),
      .MIN_HALF (3)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .clk_div  (clk_div),
      .cs_req   (cs_req),
      .tx_valid (tx_valid),
      .tx_data  (tx_data),
      .tx_ready (tx_ready),
      .rx_valid (rx_valid),
      .rx_data  (rx_data),
      .busy     (busy),
      .spi_sck  (spi_sck),
      .spi_dq_o (spi_dq_o),
      .spi_dq_i (spi_dq_i),
      .spi_cs   (spi_cs)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // One byte transfer checked against the protocol timing: accept at cycle 0,
   // H-cycle phases, MOSI per LO phase, rx_valid at 16H+1.
   task automatic xfer(input string tag, input logic [7:0] d, input int unsigned div,
                       input logic cs, input logic lp, input logic [7:0] card,
                       input int unsigned exp_h, input logic [7:0] exp_rx,
                       input logic perturb);
      int unsigned errs;
      int unsigned rises;
      int unsigned ph;
      logic        prev;
      @(negedge clk);
      chk($sformatf("%s_ready", tag), {31'd0, tx_ready}, 32'd1);
      tx_valid  = 1'b1;
      tx_data   = d;
      clk_div   = div[7:0];
      cs_req    = cs;
      loop_mode = lp;
      card_byte = card;
      @(posedge clk);
      errs  = 0;
      rises = 0;
      prev  = 1'b0;
      for (int unsigned c = 1; c <= 16 * exp_h + 1; c++) begin
         @(negedge clk);
         if (c == 1) begin
            tx_valid = 1'b0;
            if (perturb) begin
               clk_div = 8'd10;
               tx_data = ~d;
               cs_req  = ~cs;
            end
         end
         if (spi_sck && !prev) rises++;
         prev = spi_sck;
         if (c <= 16 * exp_h) begin
            ph = (c - 1) / exp_h;
            if (spi_sck !== ph[0]) errs++;
            if (!ph[0] && spi_dq_o[0] !== d[7 - ph / 2]) errs++;
            if (busy !== 1'b1 || tx_ready !== 1'b0 || rx_valid !== 1'b0) errs++;
            if (spi_cs !== ~cs || spi_dq_o[3:1] !== 3'b000) errs++;
         end
      end
      chk($sformatf("%s_rxv_at_16H+1", tag), {31'd0, rx_valid}, 32'd1);
      chk($sformatf("%s_rx_data", tag), {24'd0, rx_data}, {24'd0, exp_rx});
      chk($sformatf("%s_idle_outs", tag), {28'd0, tx_ready, busy, spi_sck, spi_dq_o[0]}, 32'b1001);
      chk($sformatf("%s_phase_errs", tag), errs, 32'd0);
      chk($sformatf("%s_sck_rises", tag), rises, 32'd8);
      dummy_rises += rises;
      for (int i = 0; i < 300 && busy; i++) @(negedge clk);
      chk($sformatf("%s_drain", tag), {31'd0, busy}, 32'd0);
      @(negedge clk);
      chk($sformatf("%s_hold", tag), {23'd0, rx_valid, rx_data}, {23'd0, 1'b0, exp_rx});
   endtask

   typedef struct {
      logic [7:0]  tx;
      int unsigned div;
      logic        cs;
      logic        lp;
      logic [7:0]  card;
      logic        perturb;
      int unsigned exp_h;
      logic [7:0]  exp_rx;
   } vec_t;

   vec_t vecs[7];

   initial begin
      int unsigned t0, t1, got;
      logic [7:0]  r0, r1;
      int unsigned nrx;

      vecs[0] = '{8'hA5, 4, 1'b1, 1'b1, 8'h00, 1'b0, 4, 8'hA5};
      vecs[1] = '{8'h3C, 3, 1'b1, 1'b0, 8'h5A, 1'b0, 3, 8'h5A};
      vecs[2] = '{8'h00, 2, 1'b1, 1'b0, 8'h81, 1'b0, 3, 8'h81};
      vecs[3] = '{8'hC3, 1, 1'b0, 1'b1, 8'h00, 1'b0, 3, 8'hC3};
      vecs[4] = '{8'h7E, 6, 1'b1, 1'b0, 8'h00, 1'b0, 6, 8'h00};
      vecs[5] = '{8'h96, 0, 1'b1, 1'b1, 8'h00, 1'b1, 3, 8'h96};
      vecs[6] = '{8'h01, 5, 1'b0, 1'b0, 8'hFE, 1'b1, 5, 8'hFE};

      // Reset
      reset = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      chk("reset_outs", {26'd0, spi_sck, spi_cs, tx_ready, busy, rx_valid, 1'b0},
          {26'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
      chk("reset_dq_o", {28'd0, spi_dq_o}, 32'h1);
      chk("reset_rx_data", {24'd0, rx_data}, 32'h0);
      @(negedge clk);
      cs_req = 1'b1;
      @(negedge clk);
      @(negedge clk);

      // Table-driven vectors (loopback, card data, clamp, mid-byte input changes)
      for (int i = 0; i < 7; i++) begin
         xfer($sformatf("vec%0d", i), vecs[i].tx, vecs[i].div, vecs[i].cs, vecs[i].lp,
              vecs[i].card, vecs[i].exp_h, vecs[i].exp_rx, vecs[i].perturb);
      end

      // Randomized transfers against the reference model
      for (int i = 0; i < 12; i++) begin
         logic [7:0]  d, card;
         int unsigned div, h;
         logic        cs, lp, pt;
         d    = 8'($urandom);
         card = 8'($urandom);
         div  = $urandom_range(0, 6);
         cs   = 1'($urandom_range(0, 1));
         lp   = 1'($urandom_range(0, 1));
         pt   = 1'($urandom_range(0, 1));
         h    = (div < 3) ? 3 : div;
         // Give CS one IDLE cycle to follow the request before the byte.
         @(negedge clk);
         cs_req = cs;
         @(negedge clk);
         xfer($sformatf("rnd%0d", i), d, div, cs, lp, card, h, lp ? d : card, pt);
      end

      // Dummy clocks: ten 0xFF with CS deasserted
      @(negedge clk);
      cs_req = 1'b0;
      @(negedge clk);
      dummy_rises = 0;
      for (int i = 0; i < 10; i++) begin
         xfer($sformatf("dummy%0d", i), 8'hFF, 3, 1'b0, 1'b0, 8'hFF, 3, 8'hFF, 1'b0);
      end
      chk("dummy_total_rises", dummy_rises, 32'd80);

      // Back-to-back with tx_valid held
      @(negedge clk);
      cs_req = 1'b1;
      @(negedge clk);
      loop_mode = 1'b1;
      clk_div   = 8'd3;
      tx_valid  = 1'b1;
      tx_data   = 8'h3C;
      @(posedge clk);
      @(negedge clk);
      tx_data = 8'hC3;
      got = 0; t0 = 0; t1 = 0; r0 = 8'h00; r1 = 8'h00;
      for (int unsigned c = 1; c <= 140 && got < 2; c++) begin
         if (c > 1) @(negedge clk);
         if (got == 1 && c == t0 + 1) begin
            chk("b2b_next_lo", {30'd0, busy, spi_sck}, 32'b10);
            tx_valid = 1'b0;
         end
         if (rx_valid) begin
            if (got == 0) begin
               t0 = c; r0 = rx_data;
               chk("b2b_gap", {29'd0, tx_ready, busy, spi_sck}, 32'b100);
            end else begin
               t1 = c; r1 = rx_data;
            end
            got++;
         end
      end
      tx_valid = 1'b0;
      chk("b2b_rx_count", got, 32'd2);
      chk("b2b_t0", t0, 32'd49);
      chk("b2b_t1", t1, 32'd98);
      chk("b2b_data", {16'd0, r0, r1}, 32'h3CC3);

      // Reset mid-byte after bit 3
      @(negedge clk);
      @(negedge clk);
      tx_valid = 1'b1;
      tx_data  = 8'h5A;
      clk_div  = 8'd3;
      @(posedge clk);
      for (int unsigned c = 1; c <= 25; c++) begin
         @(negedge clk);
         if (c == 1) tx_valid = 1'b0;
      end
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("midrst_outs", {27'd0, spi_sck, spi_cs, busy, tx_ready, rx_valid},
          {27'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0});
      chk("midrst_dq_o", {28'd0, spi_dq_o}, 32'h1);
      nrx = 0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (rx_valid) nrx++;
      end
      chk("midrst_no_rxv", nrx, 32'd0);
      xfer("after_rst", 8'h69, 3, 1'b1, 1'b1, 8'h00, 3, 8'h69, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/sd_spi_master.md
# sd_spi_master

Byte-oriented SPI mode-0 master that generates the serial clock, chip select and data-out lines driving the SD-card SDIO/SPI bridge, and reassembles the bridge's synchronized MISO into bytes. Sits between the SD controller's command/data engine (valid/ready byte stream) and the bridge's quad-SPI-style port. It uses only `spi_dq_o[0]` (MOSI) and `spi_dq_i[1]` (MISO). Its sampling point absorbs the bridge's 2-flop MISO synchronizer delay.

## Interface
- `DIV_W`, default 8: width of the `clk_div` input.
- `MIN_HALF`, default 3: minimum SCK half-period in `clk` cycles; `clk_div` values below it are clamped.
- `clk`  in  1: sole clock; everything is rising-edge.
- `reset`  in  1: synchronous, active-high reset.
- `clk_div`  in  DIV_W: SCK half-period in `clk` cycles; latched at byte accept.
- `cs_req`  in  1: request to hold CS asserted (card selected).
- `tx_valid`  in  1: byte offered.
- `tx_data`  in  8: byte to shift, MSB first.
- `tx_ready`  out  1: block can accept a byte.
- `rx_valid`  out  1: one-cycle pulse; `rx_data` valid. No backpressure.
- `rx_data`  out  8: byte received during the last transfer.
- `busy`  out  1: byte in flight.
- `spi_sck`  out  1: serial clock; idle low.
- `spi_dq_o`  out  4: bit 0 is MOSI (idle high); bits 3:1 are tied 0.
- `spi_dq_i`  in  4: bit 1 is synchronized MISO; other bits are ignored.
- `spi_cs`  out  1: active-low chip select.

## Operation
- States: IDLE, LO, HI.
- IDLE:
  - `tx_ready`=1, `busy`=0, SCK=0.
  - `spi_cs` = ~`cs_req`, updated every IDLE cycle. CS never changes outside IDLE.
  - On `tx_valid && tx_ready`: load shift register with `tx_data`; latch H = max(`clk_div`, MIN_HALF); bit count = 7; go to LO.
- LO, H cycles:
  - SCK=0; MOSI = shift[7].
- HI, H cycles:
  - SCK=1.
  - On the last HI cycle, shift in `spi_dq_i[1]` at LSB and shift left.
  - If bit count = 0, go to IDLE and pulse `rx_valid` with the assembled byte. Otherwise decrement the count and go to LO.
- Sample timing: sampling at the end of HI (not at the SCK rise) gives H−1 ≥ 2 cycles of slack for the bridge synchronizer.
- Dummy clocks (SD init needs ≥74 with CS high): send 0xFF bytes with `cs_req`=0. Bytes are shifted regardless of CS.
- `rx_data` holds its value until the next `rx_valid`.
- Inputs `clk_div`, `cs_req` and `tx_data` are ignored mid-byte.

## Timing
- Reset values: `spi_sck`=0, `spi_cs`=1, `spi_dq_o`=4'b0001, `tx_ready`=1, `busy`=0, `rx_valid`=0, `rx_data`=0, state IDLE.
- Accept at cycle 0:
  - MOSI = bit 7 and `busy`=1 from cycle 1.
  - First SCK rise at cycle 1+H.
  - Byte spans 16H cycles.
  - `rx_valid` and `tx_ready` both high at cycle 16H+1.
- Back-to-back bytes: a byte may be accepted in the same cycle `rx_valid` pulses. Inter-byte gap is exactly 1 IDLE cycle with SCK low, so the next LO starts at 16H+2.
- CS timing:
  - CS assert/deassert takes effect 1 cycle after `cs_req` is sampled in IDLE.
  - If `cs_req` and `tx_valid` rise together, CS falls in the same cycle that LO starts. The controller is responsible for ensuring setup by raising `cs_req` ≥1 byte-time early or sending a dummy byte.
- Reset mid-byte: abort next cycle with reset values; no `rx_valid`.
- Clamp: `clk_div` of 0, 1 or 2 gives H=3.
- Counter width: DIV_W; the counter wraps only through reload.

## Structure
- Package `sd_spi_pkg`: state enum (IDLE/LO/HI), `MIN_HALF` default, MOSI idle level constant.
- One natural sub-module, `sd_spi_sck_gen`:
  - Half-period down-counter with latched H.
  - Emits `half_done` (last cycle of a phase).
  - FSM and shift register stay in the top.

## Test plan
- Reset: assert `reset` for 2 cycles -> all outputs equal the reset values; `tx_ready`=1.
- Loopback: `clk_div`=4, `cs_req`=1, model a 2-flop MISO delay from MOSI, send 0xA5 -> MOSI pattern 1010_0101 on LO phases; `rx_valid` at cycle 65 with `rx_data`=0xA5; `spi_cs`=0 throughout.
- Back-to-back: hold `tx_valid` with 0x3C then 0xC3, `clk_div`=3 -> second accept in the `rx_valid` cycle; 1-cycle SCK-low gap; both bytes returned.
- Dummy clocks: `cs_req`=0, send ten 0xFF -> 80 SCK pulses; `spi_cs`=1 and MOSI=1 throughout.
- Clamp and latch: `clk_div`=0 at accept, change it to 10 mid-byte -> every phase is 3 cycles; the byte takes 48 cycles.
- Reset mid-byte: assert `reset` after bit 3 -> next cycle SCK=0, CS=1, IDLE; no `rx_valid`; a following byte transfers correctly.
